// File: rtl/mm_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mm_uart_tx_if
// Brief    : Avalon-MM agent bundle for the console transmitter register window.
// Revision : 1.0
// ============================================================================
interface mm_uart_tx_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid, waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/mm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : mm_uart_tx
// Brief    : Memory-mapped console transmitter: byte FIFO feeding an 8N1 serializer.
// Revision : 1.0
// ============================================================================
module mm_uart_tx #(
  parameter logic [31:0] BASE       = 32'h0000_2000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  mm_uart_tx_if.slave bus,
  output logic        txd
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [7:0]    c_depth     = 8'(FIFO_DEPTH);
  localparam logic [BW-1:0] c_baud_last = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [7:0]    r_count;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;

  logic [31:0]   r_readdata;
  logic          r_readdatavalid;

  logic          w_hit;
  logic          w_txdata_sel;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_read_ok;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_hit        = (bus.address[31:3] == BASE[31:3]);
  assign w_txdata_sel = w_hit & ~bus.address[2];
  assign w_full       = (r_count == c_depth);
  assign w_empty      = (r_count == 8'd0);

  // A write lane without byte 0 is accepted but carries no character.
  assign w_push    = bus.write & w_txdata_sel & bus.byteenable[0] & ~w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_read_ok = bus.read & ~bus.write;

  assign w_status = {16'h0000, r_count, 5'b00000, (r_state != S_IDLE), w_empty, w_full};

  assign bus.waitrequest   = bus.write & w_txdata_sel & w_full;
  assign bus.readdata      = r_readdata;
  assign bus.readdatavalid = r_readdatavalid;
  assign txd               = r_txd;

  assign w_unused = ^{bus.writedata[31:8], bus.byteenable[3:1], bus.address[1:0]};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= 8'd0;
      r_state         <= S_IDLE;
      r_baud          <= '0;
      r_bit_idx       <= 3'd0;
      r_shift         <= 8'h00;
      r_txd           <= 1'b1;
      r_readdata      <= 32'h0000_0000;
      r_readdatavalid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 8'd1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 8'd1;
      end

      r_readdatavalid <= w_read_ok;
      if (w_read_ok) begin
        r_readdata <= (w_hit && bus.address[2]) ? w_status : 32'h0000_0000;
      end

      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= '0;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_baud == c_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_txd     <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == c_baud_last) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // Shift register keeps the next bit in position 1 while bit 0 is on the line.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (r_baud == c_baud_last) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_uart_tx
// Brief    : Directed self-checking bench for mm_uart_tx with a serial-line monitor.
// Revision : 1.0
// ============================================================================
module tb_mm_uart_tx;
  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] A_TX   = 32'h0000_2000;
  localparam logic [31:0] A_STAT = 32'h0000_2004;
  localparam logic [31:0] A_MISS = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;

  mm_uart_tx_if bus();

  mm_uart_tx #(
    .BASE       (A_TX),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .txd (txd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  rx_q[$];
  int unsigned starts[$];
  bit          frame_err = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int stalls);
    stalls          = 0;
    bus.address     = a;
    bus.writedata   = d;
    bus.byteenable  = be;
    bus.write       = 1'b1;
    while (bus.waitrequest && stalls < 1000) begin
      tick();
      stalls++;
    end
    tick();
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    bus.address = a;
    bus.read    = 1'b1;
    tick();
    bus.read = 1'b0;
    d = bus.readdata;
    v = bus.readdatavalid;
  endtask

  task automatic mon_wait(input int n, inout bit abort);
    repeat (n) begin
      @(negedge clk);
      if (rst) abort = 1'b1;
    end
  endtask

  // Line receiver: samples mid-bit on the falling clock edge, drops frames cut by reset.
  initial begin : g_monitor
    logic        prev;
    logic [7:0]  b;
    bit          abort;
    int unsigned t;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !txd) begin
        t     = cyc;
        abort = 1'b0;
        mon_wait(CLK_DIV / 2, abort);
        if (!abort && txd !== 1'b0) frame_err = 1'b1;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CLK_DIV, abort);
          b[i] = txd;
        end
        mon_wait(CLK_DIV, abort);
        if (!abort && txd !== 1'b1) frame_err = 1'b1;
        if (!abort) begin
          rx_q.push_back(b);
          starts.push_back(t);
        end
        prev = abort ? 1'b1 : txd;
      end else begin
        prev = txd;
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic        rv;
    int          st;
    int          stall_q[10];
    int unsigned tpop;
    int          w;
    bit          any_low;
    logic [9:0]  frame;

    bus.address    = 32'h0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = 32'h0;
    bus.byteenable = 4'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_rdv", 32'(bus.readdatavalid), 32'd0);
    check("reset_wait", 32'(bus.waitrequest), 32'd0);
    check("reset_rdata", bus.readdata, 32'h0);
    bus_read(A_STAT, rd, rv);
    check("reset_status_v", 32'(rv), 32'd1);
    check("reset_status", rd, 32'h0000_0002);

    // Byte lane 0 disabled: write is accepted and dropped; STATUS writes ignored
    bus_write(A_TX, 32'h0000_00AA, 4'b1110, st);
    check("be1110_stall", 32'(st), 32'd0);
    bus_write(A_STAT, 32'hFFFF_FFFF, 4'b1111, st);
    check("wstat_stall", 32'(st), 32'd0);
    any_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (txd !== 1'b1) any_low = 1'b1;
      tick();
    end
    check("be1110_txd_idle", 32'(any_low), 32'd0);
    bus_read(A_STAT, rd, rv);
    check("be1110_status", rd, 32'h0000_0002);

    // Decode miss read returns 0 even after a nonzero readdata
    bus_read(A_MISS, rd, rv);
    check("miss_read_v", 32'(rv), 32'd1);
    check("miss_read", rd, 32'h0);
    bus_write(A_MISS, 32'h0000_0077, 4'b0001, st);
    check("miss_write_stall", 32'(st), 32'd0);
    bus_read(A_STAT, rd, rv);
    check("miss_write_status", rd, 32'h0000_0002);

    // read+write together: write serviced, read gets no response
    bus.address    = A_STAT;
    bus.writedata  = 32'h0;
    bus.byteenable = 4'hF;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    tick();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    check("rw_collision_rdv", 32'(bus.readdatavalid), 32'd0);

    // Single byte 0x55: waveform checked every cycle from the first start-bit cycle
    bus_write(A_TX, 32'h0000_0055, 4'b0001, st);
    tick();
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      check($sformatf("b55_txd_k%0d", k), 32'(txd), 32'(frame[k / CLK_DIV]));
      if (k == 21) begin
        check("b55_mid_rdv", 32'(bus.readdatavalid), 32'd1);
        check("b55_mid_status", bus.readdata, 32'h0000_0006);
        bus.read = 1'b0;
      end
      if (k == 20) begin
        bus.address = A_STAT;
        bus.read    = 1'b1;
      end
      tick();
    end
    check("b55_after_txd", 32'(txd), 32'd1);
    bus_read(A_STAT, rd, rv);
    check("b55_after_status", rd, 32'h0000_0002);

    // Burst 0x41..0x4A: first pops at once, eight fill the FIFO, the tenth stalls
    // until the first frame ends and the next pop frees a slot.
    for (int i = 0; i < 10; i++) begin
      bus_write(A_TX, 32'h41 + 32'(i), 4'b0001, st);
      stall_q[i] = st;
    end
    for (int i = 0; i < 9; i++) check($sformatf("burst_stall_%0d", i), 32'(stall_q[i]), 32'd0);
    check("burst_stall_9", 32'(stall_q[9]), 32'd154);
    bus_read(A_STAT, rd, rv);
    check("burst_full_status", rd, 32'h0000_0805);
    w = 0;
    while (rx_q.size() < 11 && w < 3000) begin
      tick();
      w++;
    end
    check("burst_rx_count", 32'(rx_q.size()), 32'd11);
    if (rx_q.size() >= 11) begin
      check("b55_rx", 32'(rx_q[0]), 32'h55);
      for (int i = 0; i < 10; i++) check($sformatf("burst_rx_%0d", i), 32'(rx_q[1 + i]), 32'h41 + 32'(i));
      for (int i = 1; i < 10; i++)
        check($sformatf("burst_gap_%0d", i), starts[i + 1] - starts[i], 32'(10 * CLK_DIV + 1));
    end
    check("frame_err", 32'(frame_err), 32'd0);

    // Three queued behind a busy serializer
    repeat (4) tick();
    bus_write(A_TX, 32'h0000_0061, 4'b0001, st);
    bus_write(A_TX, 32'h0000_0062, 4'b0001, st);
    tpop = cyc;
    bus_write(A_TX, 32'h0000_0063, 4'b0001, st);
    bus_write(A_TX, 32'h0000_0064, 4'b0001, st);
    bus_read(A_STAT, rd, rv);
    check("q3_status_v", 32'(rv), 32'd1);
    check("q3_status", rd, 32'h0000_0304);
    tick();
    check("q3_rdv_pulse", 32'(bus.readdatavalid), 32'd0);
    check("q3_rdata_hold", bus.readdata, 32'h0000_0304);
    bus_read(A_TX, rd, rv);
    check("txdata_read_v", 32'(rv), 32'd1);
    check("txdata_read", rd, 32'h0);
    bus_write(A_TX, 32'h0000_0065, 4'b0001, st);

    // Reset in data bit 3 of 0x61 (bit3 = 0) with four queued
    while (cyc < tpop + 32'(4 * CLK_DIV + 6)) tick();
    check("pre_reset_txd", 32'(txd), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_reset_txd", 32'(txd), 32'd1);
    check("post_reset_rdv", 32'(bus.readdatavalid), 32'd0);
    check("post_reset_wait", 32'(bus.waitrequest), 32'd0);
    check("post_reset_rdata", bus.readdata, 32'h0);
    bus_read(A_STAT, rd, rv);
    check("post_reset_status", rd, 32'h0000_0002);
    any_low = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (txd !== 1'b1) any_low = 1'b1;
      tick();
    end
    check("post_reset_quiet", 32'(any_low), 32'd0);
    check("post_reset_rx", 32'(rx_q.size()), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
